// File: rtl/regfile_sb.sv
// Integer register file with two async read ports, one sync write port, optional
// write-to-read bypass and a per-register busy scoreboard for long-latency results.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned SP_IDX   = 2,
  parameter logic [31:0] SP_RESET = 32'h7FFFEFFC,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREG),
  localparam int unsigned CW      = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            WE,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            ISS_V,
  input  logic [AW-1:0]   ISS_RD,
  output logic            BUSY1,
  output logic            BUSY2,
  output logic            HAZARD,
  output logic [CW-1:0]   PEND_CNT
);

  localparam logic [XLEN-1:0] SP_RST = XLEN'(SP_RESET);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   pend_nxt;
  logic            wr_v;
  logic            set_v;
  logic            set_new;
  logic            clr_real;
  logic            fwd1;
  logic            fwd2;
  logic            fwd_i;

  assign wr_v  = WE && (A3 != '0);
  assign set_v = ISS_V && (ISS_RD != '0);

  // Storage: x0 is never written so its slot simply stays at its reset value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= (i == SP_IDX) ? SP_RST : '0;
      end
    end else if (wr_v) begin
      mem[A3] <= WD3;
    end
  end

  // Scoreboard next state: a new issue supersedes a completing write to the same register
  always_comb begin
    busy_nxt = busy;
    set_new  = set_v && !busy[ISS_RD];
    clr_real = wr_v && busy[A3] && !(set_v && (ISS_RD == A3));
    if (wr_v) begin
      busy_nxt[A3] = 1'b0;
    end
    if (set_v) begin
      busy_nxt[ISS_RD] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    pend_nxt = PEND_CNT + CW'(set_new) - CW'(clr_real);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      PEND_CNT <= '0;
    end else begin
      busy     <= busy_nxt;
      PEND_CNT <= pend_nxt;
    end
  end

  // Forwarding of the write in flight this cycle
  always_comb begin
    fwd1  = BYPASS && wr_v && (A3 == A1);
    fwd2  = BYPASS && wr_v && (A3 == A2);
    fwd_i = BYPASS && wr_v && (A3 == ISS_RD);
  end

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (A1 != '0) begin
      RD1 = fwd1 ? WD3 : mem[A1];
    end
    if (A2 != '0) begin
      RD2 = fwd2 ? WD3 : mem[A2];
    end
  end

  always_comb begin
    BUSY1  = busy[A1] && !fwd1;
    BUSY2  = busy[A2] && !fwd2;
    HAZARD = BUSY1 || BUSY2 || (ISS_V && busy[ISS_RD] && !fwd_i);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_sb;

  localparam logic [31:0] SP = 32'h7FFFEFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1, a2, a3, iss_rd;
  logic        we, iss_v;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, n_rd1, n_rd2;
  logic        busy1, busy2, hazard, n_busy1, n_busy2, n_hazard;
  logic [5:0]  pend, n_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
    .WE(we), .A3(a3), .WD3(wd3), .ISS_V(iss_v), .ISS_RD(iss_rd),
    .BUSY1(busy1), .BUSY2(busy2), .HAZARD(hazard), .PEND_CNT(pend)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(n_rd1), .RD2(n_rd2),
    .WE(we), .A3(a3), .WD3(wd3), .ISS_V(iss_v), .ISS_RD(iss_rd),
    .BUSY1(n_busy1), .BUSY2(n_busy2), .HAZARD(n_hazard), .PEND_CNT(n_pend)
  );

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        hz;
    logic [5:0]  pend;
    logic [31:0] nrd1;
    logic        nb1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd, logic iv, logic [4:0] ir,
                              logic [4:0] ra1, logic [4:0] ra2, logic [31:0] e1, logic [31:0] e2,
                              logic eb1, logic eb2, logic ehz, logic [5:0] ep,
                              logic [31:0] en1, logic enb1);
    vec_t v;
    v.we = w; v.a3 = wa; v.wd3 = wd; v.iss_v = iv; v.iss_rd = ir; v.a1 = ra1; v.a2 = ra2;
    v.rd1 = e1; v.rd2 = e2; v.b1 = eb1; v.b2 = eb2; v.hz = ehz; v.pend = ep;
    v.nrd1 = en1; v.nb1 = enb1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; a3 = '0; wd3 = '0; iss_v = 1'b0; iss_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         we a3  wd3           iv ir  a1  a2  rd1           rd2           b1 b2 hz pend nrd1          nb1
    vecs.push_back(mk(1, 0, 32'hDEADBEEF, 0, 0, 0, 2, 32'h0,        SP,           0, 0, 0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0));
    vecs.push_back(mk(1, 7, 32'h12345678, 0, 0, 7, 7, 32'h12345678, 32'h12345678, 0, 0, 0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 7, 0, 32'h12345678, 32'h0,        0, 0, 0, 0, 32'h12345678, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 9, 9, 3, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 9, 32'h0,        32'h0,        0, 1, 1, 1, 32'h0,        0));
    vecs.push_back(mk(1, 9, 32'hA5,       0, 0, 9, 9, 32'hA5,       32'hA5,       0, 0, 0, 1, 32'h0,        1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 9, 9, 32'hA5,       32'hA5,       0, 0, 0, 0, 32'hA5,       0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 4, 4, 4, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0));
    vecs.push_back(mk(1, 4, 32'hCAFE0004, 1, 4, 4, 5, 32'hCAFE0004, 32'h0,        0, 0, 0, 1, 32'h0,        1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 4, 0, 32'hCAFE0004, 32'h0,        1, 0, 1, 1, 32'hCAFE0004, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 4, 0, 0, 32'h0,        32'h0,        0, 0, 1, 1, 32'h0,        0));
    vecs.push_back(mk(1, 6, 32'h66,       0, 0, 6, 4, 32'h66,       32'hCAFE0004, 0, 1, 1, 1, 32'h0,        0));
    vecs.push_back(mk(1, 4, 32'h44,       0, 0, 6, 4, 32'h66,       32'h44,       0, 0, 0, 1, 32'h66,       0));
    vecs.push_back(mk(1, 2, 32'h0BAD0002, 0, 0, 2, 0, 32'h0BAD0002, 32'h0,        0, 0, 0, 0, SP,           0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 2, 4, 32'h0BAD0002, 32'h44,       0, 0, 0, 0, 32'h0BAD0002, 0));

    idle();
    rst = 1'b0; a1 = 5'd2; a2 = 5'd5;
    step();
    chk("in_reset rd1", 64'(rd1), 64'(SP));
    chk("in_reset pend", 64'(pend), 64'd0);
    rst = 1'b1;
    #1;
    chk("reset rd1_sp", 64'(rd1), 64'(SP));
    chk("reset rd2_x5", 64'(rd2), 64'd0);
    chk("reset pend", 64'(pend), 64'd0);
    chk("reset busy", 64'({busy1, busy2, hazard}), 64'd0);
    step();

    foreach (vecs[i]) begin
      we = vecs[i].we; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
      iss_v = vecs[i].iss_v; iss_rd = vecs[i].iss_rd; a1 = vecs[i].a1; a2 = vecs[i].a2;
      #2;
      chk($sformatf("v%0d rd1", i), 64'(rd1), 64'(vecs[i].rd1));
      chk($sformatf("v%0d rd2", i), 64'(rd2), 64'(vecs[i].rd2));
      chk($sformatf("v%0d busy1", i), 64'(busy1), 64'(vecs[i].b1));
      chk($sformatf("v%0d busy2", i), 64'(busy2), 64'(vecs[i].b2));
      chk($sformatf("v%0d hazard", i), 64'(hazard), 64'(vecs[i].hz));
      chk($sformatf("v%0d pend", i), 64'(pend), 64'(vecs[i].pend));
      chk($sformatf("v%0d nob_rd1", i), 64'(n_rd1), 64'(vecs[i].nrd1));
      chk($sformatf("v%0d nob_busy1", i), 64'(n_busy1), 64'(vecs[i].nb1));
      step();
    end

    // Back-to-back issue of every register: count saturates at NREG-1 without wrapping
    idle();
    for (int r = 1; r < 32; r++) begin
      iss_v = 1'b1; iss_rd = 5'(r);
      #2;
      chk($sformatf("issue%0d pend", r), 64'(pend), 64'(r - 1));
      step();
    end
    iss_rd = 5'd5;
    #2;
    chk("reissue hazard", 64'(hazard), 64'd1);
    chk("reissue pend", 64'(pend), 64'd31);
    step();
    idle();
    a1 = 5'd31; a2 = 5'd0;
    #2;
    chk("full pend", 64'(pend), 64'd31);
    chk("full nob_pend", 64'(n_pend), 64'd31);
    chk("full busy1", 64'(busy1), 64'd1);

    // Asynchronous reset between edges, held over an edge with a write pending
    we = 1'b1; a3 = 5'd9; wd3 = 32'h11111111; a1 = 5'd2; a2 = 5'd31;
    #1;
    rst = 1'b0;
    #1;
    chk("midrst pend", 64'(pend), 64'd0);
    chk("midrst busy2", 64'(busy2), 64'd0);
    chk("midrst hazard", 64'(hazard), 64'd0);
    chk("midrst rd1_sp", 64'(rd1), 64'(SP));
    chk("midrst nob_rd1_sp", 64'(n_rd1), 64'(SP));
    step();
    rst = 1'b1;
    idle();
    a1 = 5'd9; a2 = 5'd4;
    #2;
    chk("postrst rd1_x9", 64'(rd1), 64'd0);
    chk("postrst rd2_x4", 64'(rd2), 64'd0);
    chk("postrst pend", 64'(pend), 64'd0);
    iss_v = 1'b1; iss_rd = 5'd3;
    step();
    idle();
    a1 = 5'd3;
    #2;
    chk("postrst issue pend", 64'(pend), 64'd1);
    chk("postrst issue busy1", 64'(busy1), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
